// File: rtl/mure_pkg.sv
// ============================================================================
// Module      : mure_pkg
// Description : Shared commit-path types and sizing constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mure_pkg;

    localparam int FIFO_DEPTH   = 16;
    localparam int DROP_CNT_LEN = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd_addr;
        logic        rd_we;
    } fifo_entry_s;

endpackage

`default_nettype wire

// File: rtl/commit_fifo.sv
// ============================================================================
// Module      : commit_fifo
// Description : Dual-push, single-pop show-ahead FIFO between commit and fsm;
//               never stalls commit, drops and counts entries that do not fit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_fifo
    import mure_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid0_i,
    input  fifo_entry_s                  entry0_i,
    input  logic                         valid1_i,
    input  fifo_entry_s                  entry1_i,
    input  logic                         pop_i,
    output fifo_entry_s                  entry_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         overflow_o,
    output logic [DROP_CNT_LEN-1:0]      drop_cnt_o
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_TWO   = c_CNT_W'(2);

    fifo_entry_s                 mem_q [DEPTH];

    logic [c_PTR_W-1:0]          wr_ptr_q,   wr_ptr_d;
    logic [c_PTR_W-1:0]          rd_ptr_q,   rd_ptr_d;
    logic [c_CNT_W-1:0]          count_q,    count_d;
    logic                        empty_q,    empty_d;
    logic                        full_q,     full_d;
    logic                        overflow_q, overflow_d;
    logic [DROP_CNT_LEN-1:0]     drop_cnt_q, drop_cnt_d;

    logic                        pop_en;
    logic [c_CNT_W-1:0]          free;
    logic [1:0]                  n_valid;
    logic [1:0]                  n_acc;
    logic [1:0]                  n_drop;
    logic                        we0;
    logic                        we1;
    fifo_entry_s                 wdata0;
    logic [c_PTR_W-1:0]          wr_ptr_nxt;
    logic [DROP_CNT_LEN:0]       drop_sum;

    always_comb begin
        pop_en     = pop_i & ~empty_q;
        // pop_en is only set when count_q >= 1, so free never exceeds DEPTH
        free       = c_DEPTH_CNT - count_q + c_CNT_W'(pop_en);
        n_valid    = {1'b0, valid0_i} + {1'b0, valid1_i};

        if (free >= c_CNT_TWO) begin
            n_acc = n_valid;
        end else if (free == c_CNT_ONE) begin
            n_acc = (n_valid != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            n_acc = 2'd0;
        end
        n_drop     = n_valid - n_acc;

        // Port 0 is older, so a lone port-1 entry takes the first free slot
        we0        = (n_acc != 2'd0);
        we1        = (n_acc == 2'd2);
        wdata0     = valid0_i ? entry0_i : entry1_i;
        wr_ptr_nxt = wr_ptr_q + c_PTR_W'(1);

        wr_ptr_d   = wr_ptr_q + c_PTR_W'(n_acc);
        rd_ptr_d   = rd_ptr_q + c_PTR_W'(pop_en);
        count_d    = count_q + c_CNT_W'(n_acc) - c_CNT_W'(pop_en);
        empty_d    = (count_d == '0);
        full_d     = (count_d == c_DEPTH_CNT);

        drop_sum   = {1'b0, drop_cnt_q} + (DROP_CNT_LEN + 1)'(n_drop);
        drop_cnt_d = drop_sum[DROP_CNT_LEN] ? '1 : drop_sum[DROP_CNT_LEN-1:0];
        overflow_d = overflow_q | (n_drop != 2'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (we0) begin
                mem_q[wr_ptr_q] <= wdata0;
            end
            if (we1) begin
                mem_q[wr_ptr_nxt] <= entry1_i;
            end
        end
    end

    assign entry_o    = empty_q ? '0 : mem_q[rd_ptr_q];
    assign empty_o    = empty_q;
    assign full_o     = full_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_commit_fifo.sv
// ============================================================================
// Module      : tb_commit_fifo
// Description : Directed scoreboard bench for commit_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_fifo;
    import mure_pkg::*;

    localparam int c_DEPTH = FIFO_DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid0, valid1, pop;
    fifo_entry_s entry0, entry1, entry_out;
    logic        empty, full, overflow;
    logic [4:0]  count;
    logic [15:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    fifo_entry_s sb_q[$];
    int          exp_drop = 0;
    logic        exp_ovf  = 1'b0;

    always #5 clk = ~clk;

    commit_fifo #(.DEPTH(c_DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid0_i   (valid0),
        .entry0_i   (entry0),
        .valid1_i   (valid1),
        .entry1_i   (entry1),
        .pop_i      (pop),
        .entry_o    (entry_out),
        .empty_o    (empty),
        .full_o     (full),
        .count_o    (count),
        .overflow_o (overflow),
        .drop_cnt_o (drop_cnt)
    );

    function automatic fifo_entry_s mk(input int n);
        fifo_entry_s e;
        e.pc      = 32'h1000 + 32'(n * 4);
        e.instr   = $urandom;
        e.rd_addr = 5'(n);
        e.rd_we   = n[0];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        fifo_entry_s front;
        front = (sb_q.size() != 0) ? sb_q[0] : '0;
        chk("count",    128'(count),     128'(sb_q.size()));
        chk("empty",    128'(empty),     128'(sb_q.size() == 0));
        chk("full",     128'(full),      128'(sb_q.size() == c_DEPTH));
        chk("entry",    128'(entry_out), 128'(front));
        chk("drop_cnt", 128'(drop_cnt),  128'(exp_drop));
        chk("overflow", 128'(overflow),  128'(exp_ovf));
    endtask

    // One clock of stimulus; the scoreboard is updated with what should happen at the edge.
    task automatic step(input logic v0, input fifo_entry_s e0,
                        input logic v1, input fifo_entry_s e1,
                        input logic p,  input logic r);
        int free;
        @(negedge clk);
        valid0 = v0; entry0 = e0;
        valid1 = v1; entry1 = e1;
        pop    = p;  rst    = r;
        if (r) begin
            sb_q.delete();
            exp_drop = 0;
            exp_ovf  = 1'b0;
        end else begin
            if (p && sb_q.size() != 0) void'(sb_q.pop_front());
            free = c_DEPTH - sb_q.size();
            if (v0) begin
                if (free > 0) begin sb_q.push_back(e0); free--; end
                else begin exp_drop++; exp_ovf = 1'b1; end
            end
            if (v1) begin
                if (free > 0) begin sb_q.push_back(e1); free--; end
                else begin exp_drop++; exp_ovf = 1'b1; end
            end
            if (exp_drop > 16'hFFFF) exp_drop = 16'hFFFF;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_pop();
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        fifo_entry_s a, b;
        int n;
        valid0 = 1'b0; valid1 = 1'b0; pop = 1'b0; rst = 1'b1;
        entry0 = '0;   entry1 = '0;

        // Reset then idle
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle();

        // Dual push A/B then two pops
        a = mk(1); b = mk(2);
        step(1'b1, a, 1'b1, b, 1'b0, 1'b0);
        do_pop();
        do_pop();
        do_pop();   // pop on empty is a no-op

        // Port 1 alone
        step(1'b0, '0, 1'b1, mk(3), 1'b0, 1'b0);
        do_pop();

        // Fill to 15, then dual push with no room for port 1
        n = 10;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, mk(n), 1'b1, mk(n + 1), 1'b0, 1'b0);
            n += 2;
        end
        step(1'b1, mk(n), 1'b0, '0, 1'b0, 1'b0);
        n++;
        step(1'b1, mk(n), 1'b1, mk(n + 1), 1'b0, 1'b0);
        n += 2;

        // Full with pop: one accepted, one dropped
        step(1'b1, mk(n), 1'b1, mk(n + 1), 1'b1, 1'b0);
        n += 2;
        // Full without pop: both dropped
        step(1'b1, mk(n), 1'b1, mk(n + 1), 1'b0, 1'b0);
        n += 2;

        // Drain and verify order
        for (int i = 0; i < c_DEPTH + 1; i++) do_pop();

        // 40 dual pushes with alternating pops, then reset mid-stream
        for (int i = 0; i < 40; i++) begin
            step(1'b1, mk(n), 1'b1, mk(n + 1), i[0], 1'b0);
            n += 2;
        end
        for (int i = 0; i < 6; i++) do_pop();
        step(1'b1, mk(n), 1'b1, mk(n + 1), 1'b1, 1'b1);
        idle();

        // Wrap with a draining consumer: two pushes and one pop alternate with pops
        for (int i = 0; i < 24; i++) begin
            step(1'b1, mk(n), 1'b1, mk(n + 1), 1'b1, 1'b0);
            n += 2;
            do_pop();
        end
        for (int i = 0; i < c_DEPTH; i++) do_pop();

        // Drop counter saturation
        for (int i = 0; i < 8; i++) step(1'b1, mk(i), 1'b1, mk(i + 1), 1'b0, 1'b0);
        for (int i = 0; i < 32770; i++) step(1'b1, mk(i), 1'b1, mk(i + 1), 1'b0, 1'b0);
        chk("drop_sat", 128'(drop_cnt), 128'(16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/commit_fifo.md
COMMIT_FIFO -- requirements
Module: commit_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of stored entries; power of two, >= 4.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port valid0_i  input  1  commit port 0 holds a retired instruction.
REQ-005 SHALL have port entry0_i  input  fifo_entry_s  commit port 0 payload.
REQ-006 SHALL have port valid1_i  input  1  commit port 1 holds a retired instruction (younger than port 0).
REQ-007 SHALL have port entry1_i  input  fifo_entry_s  commit port 1 payload.
REQ-008 SHALL have port pop_i  input  1  downstream fsm consumed entry_o this cycle.
REQ-009 SHALL have port entry_o  output  fifo_entry_s  oldest stored entry (show-ahead).
REQ-010 SHALL have port empty_o  output  1  no entry stored.
REQ-011 SHALL have port full_o  output  1  count equals DEPTH.
REQ-012 SHALL have port count_o  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 SHALL have port overflow_o  output  1  sticky: at least one entry dropped since reset.
REQ-014 SHALL have port drop_cnt_o  output  16  saturating count of dropped entries.

Function
REQ-015 SHALL drive entry_o = storage[rd_ptr] combinationally when empty_o=0, and all-zero when empty_o=1.
REQ-016 SHALL update empty_o, full_o and count_o as registered state; a pushed entry appears on entry_o, and empty_o falls, in the cycle after the push.
REQ-017 SHALL treat pop_i with empty_o=1 as a no-op (no pointer or count change).
REQ-018 SHALL compute free = DEPTH - count + (pop_i & ~empty_o), so a same-cycle pop frees a slot for same-cycle pushes.
REQ-019 SHALL accept pushes in age order: port 0 first, then port 1; a valid on port 1 alone occupies the single next slot.
REQ-020 SHALL, when both ports are valid and free = 1, store entry0_i and drop entry1_i; when free = 0, drop every valid entry.
REQ-021 SHALL never back-pressure the commit ports (no ready output); excess entries are dropped, never stalled.
REQ-022 SHALL add the number of dropped entries (0, 1 or 2) to drop_cnt_o each cycle, saturating at 16'hFFFF.
REQ-023 SHALL set overflow_o in the cycle after any drop and hold it until reset.
REQ-024 SHALL advance wr_ptr by the accepted count (0-2) and rd_ptr by the pop count (0-1), both modulo DEPTH.
REQ-025 SHALL update count as count + accepted - popped, never exceeding DEPTH and never going below 0.
REQ-026 SHALL store payloads unmodified; fields are interpreted only downstream.

Reset
REQ-027 SHALL, while rst_i=1 at a clock edge, clear wr_ptr, rd_ptr, count, overflow_o and drop_cnt_o; empty_o=1, full_o=0, entry_o all-zero.
REQ-028 SHALL ignore valid0_i, valid1_i and pop_i in any cycle where rst_i=1; a reset mid-operation discards all stored entries.
REQ-029 SHALL NOT require storage contents to be reset.

Structure
REQ-030 SHALL take fifo_entry_s from mure_pkg; mure_pkg SHALL additionally hold FIFO_DEPTH (16) and DROP_CNT_LEN (16) constants.
REQ-031 SHALL be a single flat module with no sub-module; storage is a register array with two write ports and one read port.
REQ-032 SHALL sit directly upstream of fsm: entry_o drives fsm fifo_entry_i, and fsm drives pop_i.

Verification
REQ-033 Reset then idle -> empty_o=1, count_o=0, entry_o=0, overflow_o=0, drop_cnt_o=0.
REQ-034 Push A on port 0 and B on port 1 in one cycle, then pop twice -> entry_o=A with count_o=2, then B with count_o=1, then empty_o=1.
REQ-035 Push only port 1 (C) -> next cycle entry_o=C, count_o=1.
REQ-036 Fill to 15, push 2 with no pop -> count_o=16, full_o=1, drop_cnt_o=1, overflow_o=1, port-1 entry absent on readout.
REQ-037 At full, push 2 with pop_i=1 -> one accepted, one dropped, count_o stays 16, drop_cnt_o increments by 1.
REQ-038 Issue 40 dual pushes with alternating pops -> pointers wrap, readout order matches push order, and rst_i=1 mid-stream -> empty_o=1 next cycle with drop_cnt_o=0.
